// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stack_arbiter
// Description : Round-robin, two-requester front-end for a 16x8 LIFO stack;
//               rejects overflow/underflow and returns pop data or an error.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_op,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_op,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp0_err,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_data_in,
    input  logic [DATA_W-1:0] stk_data_out,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_CAPT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic              r_rr;
    logic              r_owner;
    logic              r_op;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic [DATA_W-1:0] r_rsp_data;

    logic w_any_valid;
    logic w_grant;
    logic w_accept;
    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_resp;

    // With both valid the rr pointer decides; otherwise the lone requester wins.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant     = (req0_valid && req1_valid) ? r_rr : !req0_valid;
    assign w_accept    = rst && (r_state == c_IDLE) && w_any_valid;

    assign req0_ready  = w_accept && !w_grant;
    assign req1_ready  = w_accept && w_grant;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_count;

    assign w_push_ok   = (r_state == c_ISSUE) && !r_op && !w_full;
    assign w_pop_ok    = (r_state == c_ISSUE) && r_op && !w_empty;

    assign stk_push    = w_push_ok;
    assign stk_pop     = w_pop_ok;
    assign stk_data_in = w_push_ok ? r_data : '0;

    assign w_resp      = (r_state == c_RESP);
    assign rsp0_valid  = w_resp && !r_owner;
    assign rsp1_valid  = w_resp && r_owner;
    assign rsp0_err    = rsp0_valid && r_err;
    assign rsp1_err    = rsp1_valid && r_err;
    assign rsp0_data   = rsp0_valid ? r_rsp_data : '0;
    assign rsp1_data   = rsp1_valid ? r_rsp_data : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_rr       <= 1'b0;
            r_owner    <= 1'b0;
            r_op       <= 1'b0;
            r_data     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant;
                        r_op    <= w_grant ? req1_op : req0_op;
                        r_data  <= w_grant ? req1_data : req0_data;
                        r_rr    <= !w_grant;
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    // Rejected operations leave count untouched, so it never wraps.
                    r_err      <= !(w_push_ok || w_pop_ok);
                    r_rsp_data <= '0;
                    if (w_push_ok) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (w_pop_ok) begin
                        r_count <= r_count - CNT_W'(1);
                        r_state <= c_CAPT;
                    end else begin
                        r_state <= c_RESP;
                    end
                end
                c_CAPT: begin
                    r_rsp_data <= stk_data_out;
                    r_state    <= c_RESP;
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_arbiter
// Description : Scoreboard bench for stack_arbiter with a LIFO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_arbiter;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req0_valid = 1'b0, req0_op = 1'b0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req1_valid = 1'b0, req1_op = 1'b0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic              stk_push, stk_pop;
    logic [DATA_W-1:0] stk_data_in;
    logic [DATA_W-1:0] stk_data_out;
    logic [CNT_W-1:0]  count;
    logic              full, empty;

    always #5 clk = ~clk;

    stack_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_data(rsp1_data),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .count(count), .full(full), .empty(empty)
    );

    // Stack block as integrated: registered read data, reset by ~rst.
    logic [DATA_W-1:0] smem [DEPTH];
    logic [3:0]        sp;
    always @(posedge clk) begin
        if (!rst) begin
            sp           <= '0;
            stk_data_out <= '0;
        end else if (stk_push) begin
            smem[sp] <= stk_data_in;
            sp       <= sp + 4'd1;
        end else if (stk_pop) begin
            stk_data_out <= smem[sp - 4'd1];
            sp           <= sp - 4'd1;
        end
    end

    typedef struct {
        bit       owner;
        bit       err;
        bit [7:0] data;
        int       t;
        int       lat;
        int       cnt;
    } rsp_t;

    typedef struct {
        bit       op;
        bit [7:0] data;
        int       t;
    } stb_t;

    rsp_t     rq[$];
    stb_t     sq[$];
    bit [7:0] mstk[$];
    bit       m_rr = 1'b0;
    bit       inflight = 1'b0;
    int       cyc = 0;
    int       rsp_seen = 0;
    int       checks = 0;
    int       failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: strobes and responses are popped from the scoreboard;
    // grants feed the LIFO model which produces the expected responses.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                rq.delete();
                sq.delete();
                mstk.delete();
                m_rr     = 1'b0;
                inflight = 1'b0;
            end else begin
                if (stk_push || stk_pop) begin
                    chk("strobe_exclusive", 32'(stk_push && stk_pop), 32'd0);
                    if (sq.size() == 0) begin
                        flag("unexpected_strobe");
                    end else begin
                        stb_t s;
                        s = sq.pop_front();
                        chk("strobe_kind", 32'(stk_pop), 32'(s.op));
                        if (!s.op) chk("stk_data_in", 32'(stk_data_in), 32'(s.data));
                        chk("strobe_cycle", cyc, s.t);
                    end
                end
                if (rsp0_valid || rsp1_valid) begin
                    rsp_seen++;
                    chk("rsp_one_owner", 32'(rsp0_valid && rsp1_valid), 32'd0);
                    if (rq.size() == 0) begin
                        flag("unexpected_rsp");
                    end else begin
                        rsp_t e;
                        bit   o;
                        e = rq.pop_front();
                        o = rsp1_valid;
                        chk("rsp_owner", 32'(o), 32'(e.owner));
                        chk("rsp_err", 32'(o ? rsp1_err : rsp0_err), 32'(e.err));
                        chk("rsp_data", 32'(o ? rsp1_data : rsp0_data), 32'(e.data));
                        chk("rsp_nonowner_zero", 32'(o ? {rsp0_err, rsp0_data} : {rsp1_err, rsp1_data}), 32'd0);
                        chk("rsp_cycle", cyc, e.t + e.lat);
                        chk("count", 32'(count), e.cnt);
                        chk("full", 32'(full), 32'(e.cnt == DEPTH));
                        chk("empty", 32'(empty), 32'(e.cnt == 0));
                        inflight = 1'b0;
                    end
                end
                if (req0_ready || req1_ready) begin
                    bit       w, ew, op, err;
                    bit [7:0] d;
                    rsp_t     e;
                    stb_t     s;
                    w  = req1_ready;
                    ew = (req0_valid && req1_valid) ? m_rr : req1_valid;
                    chk("ready_exclusive", 32'(req0_ready && req1_ready), 32'd0);
                    chk("ready_needs_valid", 32'(w ? req1_valid : req0_valid), 32'd1);
                    chk("grant", 32'(w), 32'(ew));
                    chk("ready_while_busy", 32'(inflight), 32'd0);
                    op  = w ? req1_op : req0_op;
                    d   = w ? req1_data : req0_data;
                    err = (op == 1'b0) ? (mstk.size() == DEPTH) : (mstk.size() == 0);
                    e.owner = w;
                    e.err   = err;
                    e.data  = 8'h00;
                    e.t     = cyc;
                    e.lat   = 2;
                    if (!err) begin
                        s.op = op;
                        s.t  = cyc + 1;
                        s.data = d;
                        if (op == 1'b0) begin
                            mstk.push_back(d);
                        end else begin
                            e.data = mstk.pop_back();
                            e.lat  = 3;
                        end
                        sq.push_back(s);
                    end
                    e.cnt = mstk.size();
                    rq.push_back(e);
                    m_rr     = !w;
                    inflight = 1'b1;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic drive(input int n, input bit op, input bit [7:0] d, output int waited);
        bit got = 1'b0;
        waited = 0;
        if (n == 0) begin req0_valid = 1'b1; req0_op = op; req0_data = d; end
        else        begin req1_valid = 1'b1; req1_op = op; req1_data = d; end
        while (!got && waited < 200) begin
            @(negedge clk);
            if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) got = 1'b1;
            else waited++;
        end
        if (!got) flag("grant_timeout");
        @(posedge clk);
        #1;
        if (n == 0) begin req0_valid = 1'b0; req0_op = 1'b0; req0_data = '0; end
        else        begin req1_valid = 1'b0; req1_op = 1'b0; req1_data = '0; end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((rq.size() != 0 || inflight) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k == 60) flag("response_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int w;
        int seen;

        // Reset held with both requesters asking.
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_op = 1'b1;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_flags", 32'({empty, full}), 32'b10);
            chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("rst_strobes", 32'({stk_push, stk_pop, stk_data_in}), 32'd0);
            chk("rst_rsp", 32'({rsp0_valid, rsp0_err, rsp0_data, rsp1_valid, rsp1_err, rsp1_data}), 32'd0);
        end
        req0_valid = 1'b0; req0_data = '0;
        req1_valid = 1'b0; req1_op = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Push then pop.
        drive(0, 1'b0, 8'hA5, w);
        wait_idle();
        chk("count_after_push", 32'(count), 32'd1);
        drive(0, 1'b1, 8'h00, w);
        wait_idle();
        chk("empty_after_pop", 32'({empty, count}), 32'({1'b1, 5'd0}));

        // Fill, overflow, drain, underflow.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b0, 8'(i), w);
        end
        wait_idle();
        chk("full_after_fill", 32'({full, count}), 32'({1'b1, 5'd16}));
        drive(1, 1'b0, 8'hFF, w);
        wait_idle();
        chk("count_after_overflow", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            drive(i % 2, 1'b1, 8'h00, w);
        end
        wait_idle();
        drive(0, 1'b1, 8'h00, w);
        wait_idle();
        chk("count_after_underflow", 32'(count), 32'd0);

        // Fairness from reset.
        pulse_reset();
        fork
            begin
                int w0;
                for (int i = 0; i < 4; i++) drive(0, 1'b0, 8'(8'h10 + i), w0);
            end
            begin
                int w1;
                for (int i = 0; i < 4; i++) drive(1, 1'b0, 8'(8'h20 + i), w1);
            end
        join
        wait_idle();

        // Lone requester with rr pointing at requester 0.
        drive(1, 1'b0, 8'h77, w);
        chk("lone_grant_wait", w, 0);
        wait_idle();

        // Randomized traffic: push-heavy first, pop-heavy later.
        fork
            begin
                int wa;
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    drive(0, ($urandom_range(0, 9) < (i < 30 ? 7 : 3)) ? 1'b0 : 1'b1, 8'($urandom_range(0, 255)), wa);
                end
            end
            begin
                int wb;
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    drive(1, ($urandom_range(0, 9) < (i < 30 ? 7 : 3)) ? 1'b0 : 1'b1, 8'($urandom_range(0, 255)), wb);
                end
            end
        join
        wait_idle();

        // Reset during a pop's capture cycle.
        drive(0, 1'b0, 8'h3C, w);
        wait_idle();
        drive(0, 1'b1, 8'h00, w);
        @(posedge clk);
        #1;
        seen = rsp_seen;
        pulse_reset();
        repeat (6) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", rsp_seen, seen);
        chk("count_after_reset", 32'({empty, full, count}), 32'({1'b1, 1'b0, 5'd0}));

        chk("scoreboard_drained", rq.size() + sq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
